uart_byte_transmitter: RTL and testbench

//  Serialises one byte per handshake onto the UART TX line (8N1, LSB first).

---
 rtl/uart_byte_transmitter.sv | 126 ++++++++++++
 tb/tb_uart_byte_transmitter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_byte_transmitter.sv
// Purpose : serialises one byte per valid/ready handshake onto a UART TX line (8N1, LSB first).
// Latency : serial_out falls on the accepting edge; ready returns 10*CPB cycles after accept.
// Backpr. : data_in_ready is high only while idle; valid without ready is dropped, never queued.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   reset_n        asynchronous active-low reset
//   data_in        byte to send, sampled only on the accepting edge
//   data_in_valid  producer offers data_in this cycle
//   data_in_ready  transmitter can accept a byte this cycle
//   serial_out     UART TX line, idle high, driven straight from a flop
`timescale 1ns/1ns
module uart_byte_transmitter #(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

    generate
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_byte_transmitter: CLOCK_FREQ/BAUD_RATE must be >= 2");
        end
    endgenerate

    localparam logic [CW-1:0] LAST_TICK = CW'(CPB - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_ready;
    logic          r_serial;

    logic w_accept;
    logic w_bit_end;

    assign w_accept  = data_in_valid & r_ready;
    assign w_bit_end = (r_clk_cnt == LAST_TICK);

    // The line level for the next bit is loaded on the same edge the FSM
    // moves, so serial_out is a pure flop output with no decode behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ready   <= 1'b0;
            r_serial  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_shift   <= data_in;
                        r_clk_cnt <= '0;
                        r_ready   <= 1'b0;
                        r_serial  <= 1'b0;
                    end else begin
                        r_ready   <= 1'b1;
                        r_serial  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_serial  <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state  <= ST_STOP;
                            r_serial <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            // shift[1] becomes shift[0] on this same edge
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_state   <= ST_IDLE;
                        r_clk_cnt <= '0;
                        r_ready   <= 1'b1;
                        r_serial  <= 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ready  <= 1'b0;
                    r_serial <= 1'b1;
                end
            endcase
        end
    end

    assign data_in_ready = r_ready;
    assign serial_out    = r_serial;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Purpose : directed bench for uart_byte_transmitter with CPB=10.
// Latency : model predicts line/ready per cycle from frame arithmetic.
// Backpr. : n/a (bench drives valid directly).
`timescale 1ns/1ns
module tb_uart_byte_transmitter;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_byte_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    // Behavioural model: a frame is the list {start=0, d[0..7], stop=1};
    // the line shows element (ticks/CPB) where ticks counts cycles since accept.
    int         m_ticks = -1;
    logic [7:0] m_byte  = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_line  = 1'b1;

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return d[i-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ticks = -1;
            m_ready = 1'b0;
        end else if (m_ticks < 0) begin
            if (m_ready && data_in_valid) begin
                m_byte  = data_in;
                m_ticks = 0;
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end else begin
            m_ticks = m_ticks + 1;
            if (m_ticks == 10*CPB) begin
                m_ticks = -1;
                m_ready = 1'b1;
            end
        end
        m_line = (m_ticks < 0) ? 1'b1 : frame_bit(m_byte, m_ticks / CPB);
    end

    // Hand-written expectations {ready, line}, one per falling clock edge.
    logic [1:0] lit_q[$];

    // Single compare process: model every cycle, literal list when queued,
    // and an extra model check just after reset_n falls (async behaviour).
    always begin
        logic [1:0] e;
        logic       from_clk;
        @(negedge clk or negedge reset_n);
        from_clk = (clk == 1'b0) && (($time % 10) == 0);
        #1;
        total = total + 1;
        if (serial_out !== m_line) begin
            bad = bad + 1;
            $display("FAIL model_line t=%0t got=%b want=%b", $time, serial_out, m_line);
        end
        total = total + 1;
        if (data_in_ready !== m_ready) begin
            bad = bad + 1;
            $display("FAIL model_ready t=%0t got=%b want=%b", $time, data_in_ready, m_ready);
        end
        if (from_clk && lit_q.size() > 0) begin
            e = lit_q.pop_front();
            total = total + 1;
            if ({data_in_ready, serial_out} !== e) begin
                bad = bad + 1;
                $display("FAIL literal t=%0t got rdy/line=%b%b want=%b%b",
                         $time, data_in_ready, serial_out, e[1], e[0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic push(input logic rdy, input logic line, input int n);
        for (int i = 0; i < n; i++) lit_q.push_back({rdy, line});
    endtask

    // bits[9] is the first bit on the line (start), bits[0] the stop bit.
    task automatic push_frame(input logic [9:0] bits, input int ncyc);
        for (int k = 0; k < ncyc; k++) lit_q.push_back({1'b0, bits[9 - k/CPB]});
    endtask

    initial begin
        // 1: reset and release
        push(1'b0, 1'b1, 3);
        tick(3);
        reset_n = 1'b1;
        push(1'b1, 1'b1, 2);
        tick(2);

        // 2: 0xA5, single-cycle valid
        data_in = 8'hA5; data_in_valid = 1'b1;
        push_frame(10'b0101001011, 100);
        push(1'b1, 1'b1, 1);
        tick(1);
        data_in_valid = 1'b0;
        tick(100);

        // 3: data_in changes right after accepting 0x3C
        data_in = 8'h3C; data_in_valid = 1'b1;
        push_frame(10'b0001111001, 100);
        push(1'b1, 1'b1, 1);
        tick(1);
        data_in_valid = 1'b0; data_in = 8'hFF;
        tick(100);

        // 4: valid held high, 0x00 then 0xFF, one idle cycle between
        data_in = 8'h00; data_in_valid = 1'b1;
        push_frame(10'b0000000001, 100);
        push(1'b1, 1'b1, 1);
        push_frame(10'b0111111111, 100);
        push(1'b1, 1'b1, 1);
        tick(1);
        data_in = 8'hFF;
        tick(101);
        data_in_valid = 1'b0;
        tick(100);

        // 5: reset pulse during data bit 3 of 0x55
        data_in = 8'h55; data_in_valid = 1'b1;
        push_frame(10'b0101010101, 44);
        tick(1);
        data_in_valid = 1'b0;
        tick(43);
        reset_n = 1'b0;
        push(1'b0, 1'b1, 2);
        tick(2);
        reset_n = 1'b1;
        push(1'b1, 1'b1, 3);
        tick(3);

        // 6: valid pulse with 0x12 while busy sending 0x81
        data_in = 8'h81; data_in_valid = 1'b1;
        push_frame(10'b0100000011, 100);
        push(1'b1, 1'b1, 6);
        tick(1);
        data_in_valid = 1'b0;
        tick(29);
        data_in = 8'h12; data_in_valid = 1'b1;
        tick(1);
        data_in_valid = 1'b0;
        tick(75);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
